pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Detects load-use and ID-stage branch-operand hazards.
- Sequences a multi-cycle multiply unit by holding the front end until it finishes.
- Drives the PC, IF/ID and ID/EX control inputs. Sits beside the ID stage, whose immediate path feeds branch-target generation.

Parameters:
- MULT_CYCLES, 4, EX occupancy of a MULT/MULTU instruction in cycles (legal range 2..15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_is_branch  in  1  ID instruction is beq/bne, compared in ID
- id_branch_taken  in  1  ID comparator result; meaningful only when id_is_branch=1
- id_jump  in  1  ID instruction is j/jal/jr
- id_mult  in  1  ID instruction is MULT/MULTU
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- ex_dst  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_dst  in  5  MEM destination register
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_bubble  out  1  zero ID/EX control signals on next edge
- busy  out  1  multiply in flight
- stall_cnt  out  CNT_W  total stall cycles

Behaviour:
- Match rule: a source register matches a destination D when its use flag is 1, D != 0, and the fields are equal. Register $0 never matches.
- haz_load = ex_mem_read & (rs or rt matches ex_dst).
- haz_br = id_is_branch & ((ex_reg_write & match ex_dst) | (mem_mem_read & match mem_dst)).
- hz = haz_load | haz_br. All hazard terms are combinational.
- FSM states: RUN and MBUSY, plus a down-counter mcnt (4 bits).
- RUN, hz=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- RUN, hz=0: pc_write=1, ifid_write=1, idex_bubble=0.
  - ifid_flush=1 when (id_is_branch & id_branch_taken) | id_jump.
  - If id_mult=1, go to MBUSY next edge with mcnt=MULT_CYCLES-1. The MULT itself advances into EX that cycle without being stalled.
- MBUSY: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, busy=1. Branch and jump flushes are suppressed while stalled.
  - mcnt decrements each cycle.
  - When mcnt==1, return to RUN next edge. Total front-end stall = MULT_CYCLES-1 cycles.
- Priority: rst_n low, then MBUSY, then hz, then flush.
- id_mult with hz=1 is not issued; it is reevaluated once hz clears.
- A second MULT in ID while in MBUSY is held. It issues in the first RUN cycle, giving back-to-back occupancy with no gap.
- Outputs are combinational from state and inputs. There is no extra latency: a hazard stalls in the same cycle it is presented.
- Reset (rst_n low, asynchronous):
  - state=RUN, mcnt=0, stall_cnt=0.
  - While rst_n is low: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, busy=0.
  - Reset during MBUSY aborts the multiply sequence immediately.
- The first edge after rst_n rises is normal RUN operation.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- Defined: stall_cnt increments by 1 on every clock edge where pc_write=0 and rst_n=1. It saturates at all-ones and never wraps.
- Not defined: stall_cnt is tied to 0 and no counter register is generated.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=8, id_rs=8, id_use_rs=1 -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle. Next cycle, with ex_mem_read=0, pc_write=1.
- $0 immunity: ex_mem_read=1, ex_dst=0, id_rt=0, id_use_rt=1 -> no stall, pc_write=1.
- Branch after ALU op: id_is_branch=1, id_branch_taken=1, ex_reg_write=1, ex_dst=9, id_rt=9 -> stall with ifid_flush=0. Next cycle, with hazard cleared -> ifid_flush=1, pc_write=1.
- Branch after load: cycle 1 has ex_mem_read=1, ex_dst=10 (stall); cycle 2 has mem_mem_read=1, mem_dst=10 (stall); cycle 3 has a taken branch -> flush. Total of 2 stall cycles (stall_cnt=2 with HAZARD_STALL_PERF_EN).
- Multiply, MULT_CYCLES=4: id_mult=1 in RUN -> busy=1 and pc_write=0 for 3 cycles, then RUN. A taken branch in ID during MBUSY produces no flush until RUN.
- Reset mid-MBUSY: rst_n low in the 2nd busy cycle -> busy=0 and idex_bubble=1 immediately. After release, state is RUN, pc_write=1, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX/MEM hazard inputs and front-end control outputs.
// master = pipeline datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_is_branch;
    logic             id_branch_taken;
    logic             id_jump;
    logic             id_mult;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       ex_dst;
    logic             mem_mem_read;
    logic [4:0]       mem_dst;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_branch_taken,
               id_jump, id_mult, ex_reg_write, ex_mem_read, ex_dst, mem_mem_read, mem_dst,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_branch_taken,
               id_jump, id_mult, ex_reg_write, ex_mem_read, ex_dst, mem_mem_read, mem_dst,
        output pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, ID-branch operand and multi-cycle MULT hold.
// Optional stall performance counter enabled by HAZARD_STALL_PERF_EN.
//
// state | meaning
// RUN   | normal issue; stalls only on a combinational hazard
// MBUSY | MULT occupying EX; front end held until mcnt reaches 1
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    pipeline_hazard_ctrl_if.slave  hzIf
);
    typedef enum logic {RUN, MBUSY} stateT;

    stateT      state;
    stateT      stateNext;
    logic [3:0] mcnt;
    logic [3:0] mcntNext;

    logic rsMatchEx, rtMatchEx, rsMatchMem, rtMatchMem;
    logic hazLoad, hazBr, hz;
    logic pcWrite, ifidWrite, ifidFlush, idexBubble, busyOut;

    // Register $0 is hardwired to zero, so it can never carry a dependence.
    assign rsMatchEx  = hzIf.id_use_rs && (hzIf.ex_dst  != 5'd0) && (hzIf.id_rs == hzIf.ex_dst);
    assign rtMatchEx  = hzIf.id_use_rt && (hzIf.ex_dst  != 5'd0) && (hzIf.id_rt == hzIf.ex_dst);
    assign rsMatchMem = hzIf.id_use_rs && (hzIf.mem_dst != 5'd0) && (hzIf.id_rs == hzIf.mem_dst);
    assign rtMatchMem = hzIf.id_use_rt && (hzIf.mem_dst != 5'd0) && (hzIf.id_rt == hzIf.mem_dst);

    assign hazLoad = hzIf.ex_mem_read && (rsMatchEx || rtMatchEx);
    assign hazBr   = hzIf.id_is_branch &&
                     ((hzIf.ex_reg_write && (rsMatchEx || rtMatchEx)) ||
                      (hzIf.mem_mem_read && (rsMatchMem || rtMatchMem)));
    assign hz      = hazLoad || hazBr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mcnt  <= 4'd0;
        end else begin
            state <= stateNext;
            mcnt  <= mcntNext;
        end
    end

    always_comb begin
        stateNext  = state;
        mcntNext   = mcnt;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b1;
        busyOut    = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (!hz) begin
                        pcWrite    = 1'b1;
                        ifidWrite  = 1'b1;
                        idexBubble = 1'b0;
                        ifidFlush  = (hzIf.id_is_branch && hzIf.id_branch_taken) || hzIf.id_jump;
                        // The MULT itself moves into EX this cycle; only later fetches wait.
                        if (hzIf.id_mult) begin
                            stateNext = MBUSY;
                            mcntNext  = 4'(MULT_CYCLES - 1);
                        end
                    end
                end
                MBUSY: begin
                    busyOut  = 1'b1;
                    mcntNext = mcnt - 4'd1;
                    if (mcnt == 4'd1) begin
                        stateNext = RUN;
                    end
                end
                default: begin
                    stateNext = RUN;
                end
            endcase
        end
    end

    assign hzIf.pc_write    = pcWrite;
    assign hzIf.ifid_write  = ifidWrite;
    assign hzIf.ifid_flush  = ifidFlush;
    assign hzIf.idex_bubble = idexBubble;
    assign hzIf.busy        = busyOut;

`ifdef HAZARD_STALL_PERF_EN
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (!pcWrite && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign hzIf.stall_cnt = stallCnt;
`else
    assign hzIf.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (MULT_CYCLES=4); expected values hand-computed.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   nVec;
    int   nMis;
    int   expStall;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hzIf ();

    pipeline_hazard_ctrl #(.MULT_CYCLES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hzIf  (hzIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
`ifdef HAZARD_STALL_PERF_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic clearIn();
        hzIf.id_rs = 5'd0;           hzIf.id_rt = 5'd0;
        hzIf.id_use_rs = 1'b0;       hzIf.id_use_rt = 1'b0;
        hzIf.id_is_branch = 1'b0;    hzIf.id_branch_taken = 1'b0;
        hzIf.id_jump = 1'b0;         hzIf.id_mult = 1'b0;
        hzIf.ex_reg_write = 1'b0;    hzIf.ex_mem_read = 1'b0;
        hzIf.ex_dst = 5'd0;          hzIf.mem_mem_read = 1'b0;
        hzIf.mem_dst = 5'd0;
    endtask

    // Check the four front-end controls plus busy and the counter in one call.
    task automatic chkCtl(input string tag, input logic pw, input logic iw, input logic fl,
                          input logic bb, input logic by);
        chk({tag, ".pc_write"},    32'(hzIf.pc_write),    32'(pw));
        chk({tag, ".ifid_write"},  32'(hzIf.ifid_write),  32'(iw));
        chk({tag, ".ifid_flush"},  32'(hzIf.ifid_flush),  32'(fl));
        chk({tag, ".idex_bubble"}, 32'(hzIf.idex_bubble), 32'(bb));
        chk({tag, ".busy"},        32'(hzIf.busy),        32'(by));
        chk({tag, ".stall_cnt"},   32'(hzIf.stall_cnt),   expCnt(expStall));
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later, far from the rising edge.
    task automatic nextCyc();
        @(negedge clk);
        clearIn();
    endtask

    initial begin
        nVec = 0;
        nMis = 0;
        expStall = 0;
        rst_n = 1'b0;
        clearIn();
        repeat (2) @(negedge clk);
        #2 chkCtl("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        nextCyc(); rst_n = 1'b1;
        #2 chkCtl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // load-use on rs
        nextCyc();
        hzIf.ex_mem_read = 1'b1; hzIf.ex_dst = 5'd8; hzIf.id_rs = 5'd8; hzIf.id_use_rs = 1'b1;
        #2 chkCtl("loaduse", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expStall = 1;
        nextCyc();
        hzIf.id_rs = 5'd8; hzIf.id_use_rs = 1'b1;
        #2 chkCtl("loaduse_clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // $0 never matches
        nextCyc();
        hzIf.ex_mem_read = 1'b1; hzIf.ex_dst = 5'd0; hzIf.id_rt = 5'd0; hzIf.id_use_rt = 1'b1;
        #2 chkCtl("reg0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // match without use flag is not a hazard
        nextCyc();
        hzIf.ex_mem_read = 1'b1; hzIf.ex_dst = 5'd5; hzIf.id_rt = 5'd5;
        #2 chkCtl("nouse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // branch after ALU op
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1; hzIf.ex_reg_write = 1'b1;
        hzIf.ex_dst = 5'd9; hzIf.id_rt = 5'd9; hzIf.id_use_rt = 1'b1;
        #2 chkCtl("br_alu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expStall = 2;
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1; hzIf.id_rt = 5'd9; hzIf.id_use_rt = 1'b1;
        #2 chkCtl("br_alu_go", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // ALU result feeding a non-branch is forwarded, no stall
        nextCyc();
        hzIf.ex_reg_write = 1'b1; hzIf.ex_dst = 5'd9; hzIf.id_rt = 5'd9; hzIf.id_use_rt = 1'b1;
        #2 chkCtl("alu_nobr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // branch after load: two stall cycles then flush
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1; hzIf.id_rs = 5'd10; hzIf.id_use_rs = 1'b1;
        hzIf.ex_mem_read = 1'b1; hzIf.ex_reg_write = 1'b1; hzIf.ex_dst = 5'd10;
        #2 chkCtl("br_ld1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expStall = 3;
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1; hzIf.id_rs = 5'd10; hzIf.id_use_rs = 1'b1;
        hzIf.mem_mem_read = 1'b1; hzIf.mem_dst = 5'd10;
        #2 chkCtl("br_ld2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expStall = 4;
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1; hzIf.id_rs = 5'd10; hzIf.id_use_rs = 1'b1;
        #2 chkCtl("br_ld3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // MEM load feeding a non-branch: no stall
        nextCyc();
        hzIf.mem_mem_read = 1'b1; hzIf.mem_dst = 5'd10; hzIf.id_rs = 5'd10; hzIf.id_use_rs = 1'b1;
        #2 chkCtl("memld_nobr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // untaken branch, then jump
        nextCyc();
        hzIf.id_is_branch = 1'b1;
        #2 chkCtl("br_nt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCyc();
        hzIf.id_jump = 1'b1;
        #2 chkCtl("jump", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // multiply: issue cycle unstalled, then 3 busy cycles with flush suppressed
        nextCyc();
        hzIf.id_mult = 1'b1;
        #2 chkCtl("mul_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCyc();
            hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1;
            #2 chkCtl($sformatf("mul_busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            expStall++;
        end
        nextCyc();
        hzIf.id_is_branch = 1'b1; hzIf.id_branch_taken = 1'b1;
        #2 chkCtl("mul_done_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // MULT held behind a load-use hazard, then issues
        nextCyc();
        hzIf.id_mult = 1'b1; hzIf.ex_mem_read = 1'b1; hzIf.ex_dst = 5'd3;
        hzIf.id_rs = 5'd3; hzIf.id_use_rs = 1'b1;
        #2 chkCtl("mul_hz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expStall++;
        nextCyc();
        hzIf.id_mult = 1'b1;
        #2 chkCtl("mul_hz_go", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // second MULT waits in ID during MBUSY, issues back-to-back
        for (int i = 0; i < 3; i++) begin
            nextCyc();
            hzIf.id_mult = 1'b1;
            #2 chkCtl($sformatf("mul2_busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            expStall++;
        end
        nextCyc();
        hzIf.id_mult = 1'b1;
        #2 chkCtl("mul2_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCyc();
        #2 chkCtl("mul2_busy0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expStall++;

        // reset in the 2nd busy cycle aborts the multiply
        nextCyc();
        #2 chk("b2_busy_pre", 32'(hzIf.busy), 32'd1);
        rst_n = 1'b0;
        expStall = 0;
        #1 chkCtl("rst_mbusy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCyc();
        rst_n = 1'b1;
        #2 chkCtl("rst_rel", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCyc();
        #2 chkCtl("rst_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
